// File: rtl/burst_memory_interface_if.sv
// Bundles the LLC, local-memory and network sides of burst_memory_interface.
// slave is the block's view; master is the environment's view.
interface burst_memory_interface_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int OFFSET_BITS    = 2,
    parameter int BEAT_BITS      = 0,
    parameter int ADDRESS_WIDTH  = 12,
    parameter int MSG_BITS       = 3,
    parameter int STATUS_BITS    = 3,
    parameter int COHERENCE_BITS = 2
);
    localparam int WPL    = 1 << OFFSET_BITS;
    localparam int BW     = 1 << BEAT_BITS;
    localparam int BUS    = STATUS_BITS + COHERENCE_BITS + DATA_WIDTH * WPL;
    localparam int BEAT_W = DATA_WIDTH * BW;

    logic [MSG_BITS-1:0]      cache2interface_msg;
    logic [ADDRESS_WIDTH-1:0] cache2interface_address;
    logic [BUS-1:0]           cache2interface_data;
    logic [MSG_BITS-1:0]      interface2cache_msg;
    logic [ADDRESS_WIDTH-1:0] interface2cache_address;
    logic [BUS-1:0]           interface2cache_data;

    logic [MSG_BITS-1:0]      mem2interface_msg;
    logic [ADDRESS_WIDTH-1:0] mem2interface_address;
    logic [BEAT_W-1:0]        mem2interface_data;
    logic [MSG_BITS-1:0]      interface2mem_msg;
    logic [ADDRESS_WIDTH-1:0] interface2mem_address;
    logic [BEAT_W-1:0]        interface2mem_data;

    logic [MSG_BITS-1:0]      network2interface_msg;
    logic [ADDRESS_WIDTH-1:0] network2interface_address;
    logic [BEAT_W-1:0]        network2interface_data;
    logic [MSG_BITS-1:0]      interface2network_msg;
    logic [ADDRESS_WIDTH-1:0] interface2network_address;
    logic [BEAT_W-1:0]        interface2network_data;

    modport slave (
        input  cache2interface_msg, cache2interface_address, cache2interface_data,
        output interface2cache_msg, interface2cache_address, interface2cache_data,
        input  mem2interface_msg, mem2interface_address, mem2interface_data,
        output interface2mem_msg, interface2mem_address, interface2mem_data,
        input  network2interface_msg, network2interface_address, network2interface_data,
        output interface2network_msg, interface2network_address, interface2network_data
    );

    modport master (
        output cache2interface_msg, cache2interface_address, cache2interface_data,
        input  interface2cache_msg, interface2cache_address, interface2cache_data,
        output mem2interface_msg, mem2interface_address, mem2interface_data,
        input  interface2mem_msg, interface2mem_address, interface2mem_data,
        output network2interface_msg, network2interface_address, network2interface_data,
        input  interface2network_msg, interface2network_address, interface2network_data
    );
endinterface

// File: rtl/burst_memory_interface.sv
// Moves cache lines between the LLC and local memory or the network in
// beats of BW words, holding each request level until its response arrives.
module burst_memory_interface #(
    parameter int DATA_WIDTH     = 8,
    parameter int OFFSET_BITS    = 2,
    parameter int BEAT_BITS      = 0,
    parameter int ADDRESS_WIDTH  = 12,
    parameter int MSG_BITS       = 3,
    parameter int STATUS_BITS    = 3,
    parameter int COHERENCE_BITS = 2,
    parameter int NODE_BITS      = 1,
    parameter int NODE_ID        = 0,
    parameter int REMOTE_EN      = 0
) (
    input logic                     clock,
    input logic                     reset,
    burst_memory_interface_if.slave bus
);
    // state   | meaning
    // IDLE    | waiting for an LLC request
    // READ    | fetching line beats, R_REQ held until MEM_SENT
    // WRITE   | writing line beats, WB_REQ held until MEM_READY
    // RESPOND | one-cycle completion message to the LLC
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] READ    = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] RESPOND = 2'd3;

    localparam int WPL     = 1 << OFFSET_BITS;
    localparam int BW      = 1 << BEAT_BITS;
    localparam int NB      = WPL / BW;
    localparam int NB_BITS = OFFSET_BITS - BEAT_BITS;
    localparam int CNT_W   = (NB_BITS > 0) ? NB_BITS : 1;
    localparam int LINE_W  = DATA_WIDTH * WPL;
    localparam int BEAT_W  = DATA_WIDTH * BW;
    localparam int BUS     = STATUS_BITS + COHERENCE_BITS + LINE_W;

    localparam logic [MSG_BITS-1:0] NO_REQ      = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] WB_REQ      = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] R_REQ       = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] FLUSH       = MSG_BITS'(3);
    localparam logic [MSG_BITS-1:0] INVLD       = MSG_BITS'(5);
    localparam logic [MSG_BITS-1:0] MEM_NO_MSG  = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] MEM_READY   = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] MEM_SENT    = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] M_RECV      = MSG_BITS'(4);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'((1 << OFFSET_BITS) - 1);

    logic [1:0]               state_q, state_d;
    logic [MSG_BITS-1:0]      cmd_q, cmd_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic                     remote_q, remote_d;
    logic [CNT_W-1:0]         beat_q, beat_d;
    logic [LINE_W-1:0]        wb_line_q, wb_line_d;
    logic [LINE_W-1:0]        rd_line_q, rd_line_d;
    logic [MSG_BITS-1:0]      req_msg_q, req_msg_d;
    logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [BEAT_W-1:0]        req_data_q, req_data_d;
    logic [MSG_BITS-1:0]      cache_msg_q, cache_msg_d;
    logic [ADDRESS_WIDTH-1:0] cache_addr_q, cache_addr_d;

    logic [MSG_BITS-1:0]      c_msg;
    logic [ADDRESS_WIDTH-1:0] c_base;
    logic [LINE_W-1:0]        c_line;
    logic                     c_dirty;
    logic                     c_remote;
    logic [MSG_BITS-1:0]      rsp_msg;
    logic [BEAT_W-1:0]        rsp_data;
    logic [CNT_W-1:0]         next_beat;

    assign c_msg    = bus.cache2interface_msg;
    assign c_base   = bus.cache2interface_address & ALIGN_MASK;
    assign c_line   = bus.cache2interface_data[LINE_W-1:0];
    assign c_dirty  = bus.cache2interface_data[BUS-2];
    assign c_remote = (REMOTE_EN != 0) &&
                      (bus.cache2interface_address[ADDRESS_WIDTH-1 -: NODE_BITS] != NODE_BITS'(NODE_ID));

    // Only the port chosen at acceptance is listened to.
    assign rsp_msg   = remote_q ? bus.network2interface_msg  : bus.mem2interface_msg;
    assign rsp_data  = remote_q ? bus.network2interface_data : bus.mem2interface_data;
    assign next_beat = beat_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        base_d       = base_q;
        remote_d     = remote_q;
        beat_d       = beat_q;
        wb_line_d    = wb_line_q;
        rd_line_d    = rd_line_q;
        req_msg_d    = req_msg_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        cache_msg_d  = MEM_NO_MSG;
        cache_addr_d = '0;
        case (state_q)
            IDLE: begin
                if (c_msg == R_REQ) begin
                    state_d    = READ;
                    cmd_d      = c_msg;
                    base_d     = c_base;
                    remote_d   = c_remote;
                    beat_d     = '0;
                    req_msg_d  = R_REQ;
                    req_addr_d = c_base;
                    req_data_d = '0;
                end else if (c_msg == WB_REQ || ((c_msg == FLUSH || c_msg == INVLD) && c_dirty)) begin
                    state_d    = WRITE;
                    cmd_d      = c_msg;
                    base_d     = c_base;
                    remote_d   = c_remote;
                    beat_d     = '0;
                    wb_line_d  = c_line;
                    req_msg_d  = WB_REQ;
                    req_addr_d = c_base;
                    req_data_d = c_line[BEAT_W-1:0];
                end else if (c_msg == FLUSH || c_msg == INVLD) begin
                    // Clean line: nothing to write back, acknowledge straight away.
                    state_d      = RESPOND;
                    cmd_d        = c_msg;
                    base_d       = c_base;
                    cache_msg_d  = M_RECV;
                    cache_addr_d = c_base;
                end
            end
            READ, WRITE: begin
                if (rsp_msg == ((state_q == READ) ? MEM_SENT : MEM_READY)) begin
                    if (state_q == READ) begin
                        for (int k = 0; k < NB; k++) begin
                            if (beat_q == CNT_W'(k)) rd_line_d[k*BEAT_W +: BEAT_W] = rsp_data;
                        end
                    end
                    if (beat_q == CNT_W'(NB - 1)) begin
                        state_d      = RESPOND;
                        beat_d       = '0;
                        req_msg_d    = NO_REQ;
                        req_addr_d   = '0;
                        req_data_d   = '0;
                        cache_addr_d = base_q;
                        if (cmd_q == R_REQ)       cache_msg_d = MEM_SENT;
                        else if (cmd_q == WB_REQ) cache_msg_d = MEM_READY;
                        else                      cache_msg_d = M_RECV;
                    end else begin
                        beat_d     = next_beat;
                        req_addr_d = base_q + (ADDRESS_WIDTH'(next_beat) << BEAT_BITS);
                        req_data_d = '0;
                        if (state_q == WRITE) begin
                            for (int k = 0; k < NB; k++) begin
                                if (next_beat == CNT_W'(k)) req_data_d = wb_line_q[k*BEAT_W +: BEAT_W];
                            end
                        end
                    end
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            base_q       <= '0;
            remote_q     <= 1'b0;
            beat_q       <= '0;
            wb_line_q    <= '0;
            rd_line_q    <= '0;
            req_msg_q    <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            cache_msg_q  <= '0;
            cache_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            base_q       <= base_d;
            remote_q     <= remote_d;
            beat_q       <= beat_d;
            wb_line_q    <= wb_line_d;
            rd_line_q    <= rd_line_d;
            req_msg_q    <= req_msg_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            cache_msg_q  <= cache_msg_d;
            cache_addr_q <= cache_addr_d;
        end
    end

    assign bus.interface2mem_msg         = remote_q ? '0 : req_msg_q;
    assign bus.interface2mem_address     = remote_q ? '0 : req_addr_q;
    assign bus.interface2mem_data        = remote_q ? '0 : req_data_q;
    assign bus.interface2network_msg     = remote_q ? req_msg_q  : '0;
    assign bus.interface2network_address = remote_q ? req_addr_q : '0;
    assign bus.interface2network_data    = remote_q ? req_data_q : '0;

    assign bus.interface2cache_msg     = cache_msg_q;
    assign bus.interface2cache_address = cache_addr_q;
    assign bus.interface2cache_data    = {1'b1, {(STATUS_BITS + COHERENCE_BITS - 1){1'b0}}, rd_line_q};

    logic unused_inputs;
    assign unused_inputs = ^{bus.mem2interface_address, bus.network2interface_address,
                             bus.cache2interface_data[BUS-1], bus.cache2interface_data[BUS-3:LINE_W]};
endmodule

// File: tb/tb_burst_memory_interface.sv
// Scoreboard bench: dut_a is the default single-word-beat local block,
// dut_b uses two-word beats with remote routing enabled.
module tb_burst_memory_interface;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    burst_memory_interface_if if_a ();
    burst_memory_interface_if #(.BEAT_BITS(1)) if_b ();

    burst_memory_interface dut_a (.clock(clock), .reset(reset), .bus(if_a));
    burst_memory_interface #(.BEAT_BITS(1), .REMOTE_EN(1), .NODE_ID(0)) dut_b (.clock(clock), .reset(reset), .bus(if_b));

    typedef struct {
        int          dut;
        int          port;
        logic [2:0]  msg;
        logic [11:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic        stall_a = 1'b0;
    logic        junk_b  = 1'b0;
    logic [7:0]  rd_words [4];

    localparam logic [63:0] STAT = 64'h10_0000_0000;

    task automatic expect_ev(input int dut, input int port, input logic [2:0] msg,
                             input logic [11:0] addr, input logic [63:0] data);
        sbq.push_back('{dut, port, msg, addr, data});
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic compare_ev(input int dut, input int port, input logic [2:0] msg,
                              input logic [11:0] addr, input logic [63:0] data);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event dut%0d port%0d: got msg %0d addr %h data %h, expected none",
                     dut, port, msg, addr, data);
        end else begin
            e = sbq.pop_front();
            if (e.dut != dut || e.port != port || e.msg !== msg || e.addr !== addr || e.data !== data) begin
                errors++;
                $display("FAIL event dut%0d: got port %0d msg %0d addr %h data %h, expected dut%0d port %0d msg %0d addr %h data %h",
                         dut, port, msg, addr, data, e.dut, e.port, e.msg, e.addr, e.data);
            end
        end
    endtask

    function automatic logic [2:0] resp_for(input logic [2:0] req);
        case (req)
            3'd2:    return 3'd2;
            3'd1:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Monitor plus memory/network responders, all sampled away from the rising edge.
    int off;
    always @(negedge clock) begin
        if (!reset) begin
            if (if_a.interface2mem_msg != 0 && !stall_a)
                compare_ev(0, 0, if_a.interface2mem_msg, if_a.interface2mem_address, 64'(if_a.interface2mem_data));
            if (if_a.interface2network_msg != 0)
                compare_ev(0, 1, if_a.interface2network_msg, if_a.interface2network_address, 64'(if_a.interface2network_data));
            if (if_a.interface2cache_msg != 0)
                compare_ev(0, 2, if_a.interface2cache_msg, if_a.interface2cache_address, 64'(if_a.interface2cache_data));
            if (if_b.interface2mem_msg != 0) begin
                compare_ev(1, 0, if_b.interface2mem_msg, if_b.interface2mem_address, 64'(if_b.interface2mem_data));
                check("b_net_idle", 64'({if_b.interface2network_msg, if_b.interface2network_address, if_b.interface2network_data}), 64'h0);
            end
            if (if_b.interface2network_msg != 0) begin
                compare_ev(1, 1, if_b.interface2network_msg, if_b.interface2network_address, 64'(if_b.interface2network_data));
                check("b_mem_idle", 64'({if_b.interface2mem_msg, if_b.interface2mem_address, if_b.interface2mem_data}), 64'h0);
            end
            if (if_b.interface2cache_msg != 0)
                compare_ev(1, 2, if_b.interface2cache_msg, if_b.interface2cache_address, 64'(if_b.interface2cache_data));
        end

        if_a.network2interface_msg     = 3'd0;
        if_a.network2interface_address = 12'h0;
        if_a.network2interface_data    = 8'h0;
        if (!reset && !stall_a) begin
            off = int'(if_a.interface2mem_address[1:0]);
            if_a.mem2interface_msg  = resp_for(if_a.interface2mem_msg);
            if_a.mem2interface_data = (if_a.interface2mem_msg == 3'd2) ? rd_words[off] : 8'h0;
        end else begin
            if_a.mem2interface_msg  = 3'd0;
            if_a.mem2interface_data = 8'h0;
        end
        if_a.mem2interface_address = if_a.interface2mem_address;

        off = int'(if_b.interface2mem_address[1:0]);
        if (!reset && if_b.interface2mem_msg != 0) begin
            if_b.mem2interface_msg  = resp_for(if_b.interface2mem_msg);
            if_b.mem2interface_data = (if_b.interface2mem_msg == 3'd2) ? {rd_words[off+1], rd_words[off]} : 16'h0;
        end else if (!reset && junk_b) begin
            if_b.mem2interface_msg  = 3'd2;
            if_b.mem2interface_data = 16'hFFFF;
        end else begin
            if_b.mem2interface_msg  = 3'd0;
            if_b.mem2interface_data = 16'h0;
        end
        if_b.mem2interface_address = if_b.interface2mem_address;

        off = int'(if_b.interface2network_address[1:0]);
        if (!reset && if_b.interface2network_msg != 0) begin
            if_b.network2interface_msg  = resp_for(if_b.interface2network_msg);
            if_b.network2interface_data = (if_b.interface2network_msg == 3'd2) ? {rd_words[off+1], rd_words[off]} : 16'h0;
        end else begin
            if_b.network2interface_msg  = 3'd0;
            if_b.network2interface_data = 16'h0;
        end
        if_b.network2interface_address = if_b.interface2network_address;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cache_req(input int dut, input logic [2:0] msg, input logic [11:0] addr, input logic [36:0] data);
        if (dut == 0) begin
            if_a.cache2interface_msg = msg; if_a.cache2interface_address = addr; if_a.cache2interface_data = data;
        end else begin
            if_b.cache2interface_msg = msg; if_b.cache2interface_address = addr; if_b.cache2interface_data = data;
        end
        tick();
        if (dut == 0) if_a.cache2interface_msg = 3'd0;
        else          if_b.cache2interface_msg = 3'd0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events still pending after %0d cycles, required 0", name, sbq.size(), budget);
            sbq.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        if_a.cache2interface_msg = 3'd0; if_a.cache2interface_address = 12'h0; if_a.cache2interface_data = 37'h0;
        if_b.cache2interface_msg = 3'd0; if_b.cache2interface_address = 12'h0; if_b.cache2interface_data = 37'h0;
        repeat (3) tick();
        check("rst_a_mem", 64'({if_a.interface2mem_msg, if_a.interface2mem_address, if_a.interface2mem_data}), 64'h0);
        check("rst_a_cache_msg", 64'({if_a.interface2cache_msg, if_a.interface2cache_address}), 64'h0);
        check("rst_a_cache_data", 64'(if_a.interface2cache_data), STAT);
        check("rst_b_net", 64'({if_b.interface2network_msg, if_b.interface2network_address, if_b.interface2network_data}), 64'h0);
        check("rst_b_cache_data", 64'(if_b.interface2cache_data), STAT);
        reset = 1'b0;
        tick();

        // Single-word read of line 0x40.
        rd_words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) expect_ev(0, 0, 3'd2, 12'h040 + 12'(i), 64'h0);
        expect_ev(0, 2, 3'd2, 12'h040, 64'h10_4433_2211);
        cache_req(0, 3'd2, 12'h040, 37'h0);
        wait_drain("read_0x40", 40);

        // Memory stalls ten cycles: request must hold and the cache sees nothing.
        rd_words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        stall_a = 1'b1;
        cache_req(0, 3'd2, 12'h044, 37'h0);
        for (int i = 0; i < 10; i++) begin
            check("stall_req", 64'({if_a.interface2mem_msg, if_a.interface2mem_address}), 64'({3'd2, 12'h044}));
            check("stall_cache", 64'(if_a.interface2cache_msg), 64'h0);
            tick();
        end
        for (int i = 0; i < 4; i++) expect_ev(0, 0, 3'd2, 12'h044 + 12'(i), 64'h0);
        expect_ev(0, 2, 3'd2, 12'h044, 64'h10_D4C3_B2A1);
        stall_a = 1'b0;
        wait_drain("read_after_stall", 40);

        // Dirty flush; cache input changes and a stray R_REQ while busy must be ignored.
        expect_ev(0, 0, 3'd1, 12'h040, 64'h12);
        expect_ev(0, 0, 3'd1, 12'h041, 64'h34);
        expect_ev(0, 0, 3'd1, 12'h042, 64'h56);
        expect_ev(0, 0, 3'd1, 12'h043, 64'h78);
        expect_ev(0, 2, 3'd4, 12'h040, 64'h10_D4C3_B2A1);
        cache_req(0, 3'd3, 12'h042, 37'h8_7856_3412);
        if_a.cache2interface_msg = 3'd2; if_a.cache2interface_address = 12'h099; if_a.cache2interface_data = 37'h8_FFFF_FFFF;
        tick();
        tick();
        if_a.cache2interface_msg = 3'd0;
        wait_drain("flush_dirty", 40);

        // Clean FLUSH / INVLD: immediate M_RECV, no memory traffic.
        expect_ev(0, 2, 3'd4, 12'h050, 64'h10_D4C3_B2A1);
        cache_req(0, 3'd3, 12'h050, 37'h0_0000_0000);
        check("flush_clean_next_cycle", 64'({if_a.interface2cache_msg, if_a.interface2cache_address}), 64'({3'd4, 12'h050}));
        check("flush_clean_no_mem", 64'(if_a.interface2mem_msg), 64'h0);
        wait_drain("flush_clean", 10);
        expect_ev(0, 2, 3'd4, 12'h054, 64'h10_D4C3_B2A1);
        cache_req(0, 3'd5, 12'h054, 37'h0_0000_0000);
        wait_drain("invld_clean", 10);

        // Reset after beat 1 of a read, then a fresh read must complete.
        rd_words = '{8'h99, 8'h88, 8'h77, 8'h66};
        expect_ev(0, 0, 3'd2, 12'h060, 64'h0);
        expect_ev(0, 0, 3'd2, 12'h061, 64'h0);
        cache_req(0, 3'd2, 12'h060, 37'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_mem", 64'({if_a.interface2mem_msg, if_a.interface2mem_address, if_a.interface2mem_data}), 64'h0);
        check("midrst_cache", 64'({if_a.interface2cache_msg, if_a.interface2cache_address}), 64'h0);
        check("midrst_line", 64'(if_a.interface2cache_data), STAT);
        check("midrst_pending", 64'(sbq.size()), 64'h0);
        reset = 1'b0;
        tick();
        rd_words = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
        for (int i = 0; i < 4; i++) expect_ev(0, 0, 3'd2, 12'h060 + 12'(i), 64'h0);
        expect_ev(0, 2, 3'd2, 12'h060, 64'h10_3C2D_1E0F);
        cache_req(0, 3'd2, 12'h060, 37'h0);
        wait_drain("read_after_reset", 40);

        // Two-word-beat write-back on the local port.
        expect_ev(1, 0, 3'd1, 12'h080, 64'hB1A0);
        expect_ev(1, 0, 3'd1, 12'h082, 64'hD3C2);
        expect_ev(1, 2, 3'd1, 12'h080, STAT);
        cache_req(1, 3'd1, 12'h080, 37'h0_D3C2_B1A0);
        wait_drain("burst_write", 40);

        // Remote read through the network while the memory port sends junk.
        rd_words = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        junk_b = 1'b1;
        expect_ev(1, 1, 3'd2, 12'h800, 64'h0);
        expect_ev(1, 1, 3'd2, 12'h802, 64'h0);
        expect_ev(1, 2, 3'd2, 12'h800, 64'h10_8D7C_6B5A);
        cache_req(1, 3'd2, 12'h800, 37'h0);
        check("route_mem_zero", 64'({if_b.interface2mem_msg, if_b.interface2mem_address, if_b.interface2mem_data}), 64'h0);
        wait_drain("remote_read", 40);
        junk_b = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
